multicycle_main_control: RTL and testbench

// Multicycle MIPS main control FSM. Decodes the 6-bit opcode and sequences the datapath through

---
 rtl/multicycle_main_control.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback and
// Moore-decodes every datapath enable from the current state.
module multicycle_main_control #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctl_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt, cnt_d;
    logic [5:0]       op_q;
    logic             last_wait;
    ctl_t             ctl_c, ctl_g;

    // State, wait counter and latched opcode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= cnt_d;
            if (state_q == S_DECODE) op_q <= opcode;
        end
    end

    // Next state and Moore output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        ctl_c     = '0;
        last_wait = (wait_cnt == LAST_CNT);
        case (state_q)
            S_FETCH: begin
                ctl_c.mem_read  = 1'b1;
                ctl_c.alu_src_b = 2'b01;
                ctl_c.alu_op    = 2'b10;
                if (last_wait) begin
                    ctl_c.ir_write = 1'b1;
                    ctl_c.pc_write = 1'b1;
                    state_d        = S_DECODE;
                end else begin
                    cnt_d = wait_cnt + 4'd1;
                end
            end
            S_DECODE: begin
                ctl_c.alu_src_b = 2'b11;
                ctl_c.alu_op    = 2'b10;
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_R:           state_d = S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_J:           state_d = S_JUMP;
                    default: begin
                        ctl_c.illegal_op = 1'b1;
                        ctl_c.instr_done = 1'b1;
                        state_d          = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl_c.alu_src_a = 1'b1;
                ctl_c.alu_src_b = 2'b10;
                ctl_c.alu_op    = 2'b10;
                if (op_q == OP_LW)      state_d = S_MEMRD;
                else if (op_q == OP_SW) state_d = S_MEMWR;
                else                    state_d = S_FETCH;
            end
            S_MEMRD: begin
                ctl_c.mem_read = 1'b1;
                ctl_c.iord     = 1'b1;
                if (last_wait) state_d = S_MEMWB;
                else           cnt_d   = wait_cnt + 4'd1;
            end
            S_MEMWB: begin
                ctl_c.reg_write  = 1'b1;
                ctl_c.mem_to_reg = 1'b1;
                ctl_c.instr_done = 1'b1;
                state_d          = S_FETCH;
            end
            S_MEMWR: begin
                ctl_c.mem_write = 1'b1;
                ctl_c.iord      = 1'b1;
                if (last_wait) begin
                    ctl_c.instr_done = 1'b1;
                    state_d          = S_FETCH;
                end else begin
                    cnt_d = wait_cnt + 4'd1;
                end
            end
            S_EXEC: begin
                ctl_c.alu_src_a = 1'b1;
                state_d         = S_ALUWB;
            end
            S_ALUWB: begin
                ctl_c.reg_write  = 1'b1;
                ctl_c.reg_dst    = 1'b1;
                ctl_c.instr_done = 1'b1;
                state_d          = S_FETCH;
            end
            S_BRANCH: begin
                ctl_c.alu_src_a        = 1'b1;
                ctl_c.alu_op           = 2'b01;
                ctl_c.pc_source        = 2'b01;
                ctl_c.pc_write_cond    = (op_q == OP_BEQ);
                ctl_c.pc_write_cond_ne = (op_q == OP_BNE);
                ctl_c.instr_done       = 1'b1;
                state_d                = S_FETCH;
            end
            S_ADDIEX: begin
                ctl_c.alu_src_a = 1'b1;
                ctl_c.alu_src_b = 2'b10;
                ctl_c.alu_op    = 2'b10;
                state_d         = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl_c.reg_write  = 1'b1;
                ctl_c.instr_done = 1'b1;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                ctl_c.pc_write   = 1'b1;
                ctl_c.pc_source  = 2'b10;
                ctl_c.instr_done = 1'b1;
                state_d          = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces every output low immediately, aborting any in-flight access
    assign ctl_g = reset ? ctl_c : '0;

    assign PCWrite       = ctl_g.pc_write;
    assign PCWriteCond   = ctl_g.pc_write_cond;
    assign PCWriteCondNE = ctl_g.pc_write_cond_ne;
    assign IorD          = ctl_g.iord;
    assign MemRead       = ctl_g.mem_read;
    assign MemWrite      = ctl_g.mem_write;
    assign MemtoReg      = ctl_g.mem_to_reg;
    assign IRWrite       = ctl_g.ir_write;
    assign RegDst        = ctl_g.reg_dst;
    assign RegWrite      = ctl_g.reg_write;
    assign ALUSrcA       = ctl_g.alu_src_a;
    assign ALUSrcB       = ctl_g.alu_src_b;
    assign ALUop         = ctl_g.alu_op;
    assign PCSource      = ctl_g.pc_source;
    assign instr_done    = ctl_g.instr_done;
    assign illegal_op    = ctl_g.illegal_op;
    assign state         = reset ? 4'(state_q) : 4'd0;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: random opcode streams on MEM_LAT=1 and MEM_LAT=3
// instances, every cycle compared against a per-instruction expected output sequence.
module tb_multicycle_main_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic       pcw, pcwc, pcwcne, iord, mrd, mwr, m2r, irw, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       done, ill;
        logic [3:0] st;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst1, rst3;
    logic [5:0] op1, op3;
    int         n_tests = 0;
    int         n_fail  = 0;
    ctl_t       exp_q[$];

    logic pcw1, pcwc1, pcwcne1, iord1, mrd1, mwr1, m2r1, irw1, rdst1, rw1, srca1, done1, ill1;
    logic pcw3, pcwc3, pcwcne3, iord3, mrd3, mwr3, m2r3, irw3, rdst3, rw3, srca3, done3, ill3;
    logic [1:0] srcb1, aluop1, pcsrc1, srcb3, aluop3, pcsrc3;
    logic [3:0] st1, st3;
    ctl_t o1, o3;

    always #5 clk = ~clk;

    multicycle_main_control #(.MEM_LAT(1)) u_l1 (
        .clk(clk), .reset(rst1), .opcode(op1),
        .PCWrite(pcw1), .PCWriteCond(pcwc1), .PCWriteCondNE(pcwcne1), .IorD(iord1),
        .MemRead(mrd1), .MemWrite(mwr1), .MemtoReg(m2r1), .IRWrite(irw1), .RegDst(rdst1),
        .RegWrite(rw1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .ALUop(aluop1), .PCSource(pcsrc1),
        .instr_done(done1), .illegal_op(ill1), .state(st1)
    );

    multicycle_main_control #(.MEM_LAT(3)) u_l3 (
        .clk(clk), .reset(rst3), .opcode(op3),
        .PCWrite(pcw3), .PCWriteCond(pcwc3), .PCWriteCondNE(pcwcne3), .IorD(iord3),
        .MemRead(mrd3), .MemWrite(mwr3), .MemtoReg(m2r3), .IRWrite(irw3), .RegDst(rdst3),
        .RegWrite(rw3), .ALUSrcA(srca3), .ALUSrcB(srcb3), .ALUop(aluop3), .PCSource(pcsrc3),
        .instr_done(done3), .illegal_op(ill3), .state(st3)
    );

    assign o1 = {pcw1, pcwc1, pcwcne1, iord1, mrd1, mwr1, m2r1, irw1, rdst1, rw1, srca1,
                 srcb1, aluop1, pcsrc1, done1, ill1, st1};
    assign o3 = {pcw3, pcwc3, pcwcne3, iord3, mrd3, mwr3, m2r3, irw3, rdst3, rw3, srca3,
                 srcb3, aluop3, pcsrc3, done3, ill3, st3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected per-cycle outputs for one instruction starting in FETCH
    task automatic build(input logic [5:0] op, input int lat);
        ctl_t c;
        exp_q.delete();
        for (int k = 0; k < lat; k++) begin
            c = '0; c.mrd = 1'b1; c.srcb = 2'b01; c.aluop = 2'b10;
            c.irw = (k == lat - 1); c.pcw = (k == lat - 1);
            exp_q.push_back(c);
        end
        c = '0; c.st = 4'd1; c.srcb = 2'b11; c.aluop = 2'b10;
        case (op)
            OP_LW, OP_SW: begin
                exp_q.push_back(c);
                c = '0; c.st = 4'd2; c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 2'b10;
                exp_q.push_back(c);
                for (int k = 0; k < lat; k++) begin
                    c = '0; c.iord = 1'b1;
                    if (op == OP_LW) begin c.st = 4'd3; c.mrd = 1'b1; end
                    else begin c.st = 4'd5; c.mwr = 1'b1; c.done = (k == lat - 1); end
                    exp_q.push_back(c);
                end
                if (op == OP_LW) begin
                    c = '0; c.st = 4'd4; c.rw = 1'b1; c.m2r = 1'b1; c.done = 1'b1;
                    exp_q.push_back(c);
                end
            end
            OP_R: begin
                exp_q.push_back(c);
                c = '0; c.st = 4'd6; c.srca = 1'b1; exp_q.push_back(c);
                c = '0; c.st = 4'd7; c.rw = 1'b1; c.rdst = 1'b1; c.done = 1'b1; exp_q.push_back(c);
            end
            OP_BEQ, OP_BNE: begin
                exp_q.push_back(c);
                c = '0; c.st = 4'd8; c.srca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
                c.pcwc = (op == OP_BEQ); c.pcwcne = (op == OP_BNE); c.done = 1'b1;
                exp_q.push_back(c);
            end
            OP_ADDI: begin
                exp_q.push_back(c);
                c = '0; c.st = 4'd9; c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 2'b10;
                exp_q.push_back(c);
                c = '0; c.st = 4'd10; c.rw = 1'b1; c.done = 1'b1; exp_q.push_back(c);
            end
            OP_J: begin
                exp_q.push_back(c);
                c = '0; c.st = 4'd11; c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1;
                exp_q.push_back(c);
            end
            default: begin
                c.ill = 1'b1; c.done = 1'b1; exp_q.push_back(c);
            end
        endcase
    endtask

    function automatic ctl_t obs(input int w);
        return (w == 1) ? o1 : o3;
    endfunction

    // Called at a negedge with the DUT in its first FETCH cycle; returns at the next FETCH.
    // abort_at >= 0 pulls reset low in that cycle and returns immediately.
    task automatic run_instr(input int w, input logic [5:0] op, input int abort_at);
        ctl_t got;
        if (w == 1) op1 = op; else op3 = op;
        build(op, (w == 1) ? 1 : 3);
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            got = obs(w);
            check($sformatf("L%0d op%b cyc%0d", w, op, i), 32'(got), 32'(exp_q[i]));
            check("aluop_11", 32'(got.aluop == 2'b11), 32'd0);
            check("pcw_overlap", 32'(got.pcw & (got.pcwc | got.pcwcne)), 32'd0);
            check("rd_wr_overlap", 32'(got.mrd & got.mwr), 32'd0);
            if (i == abort_at) begin
                if (w == 1) rst1 = 1'b0; else rst3 = 1'b0;
                #1;
                check("abort_zero", 32'(obs(w)), 32'd0);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic hold_reset(input int w, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            #1;
            check($sformatf("L%0d reset_zero", w), 32'(obs(w)), 32'd0);
            @(negedge clk);
        end
        if (w == 1) rst1 = 1'b1; else rst3 = 1'b1;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] legal [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
        int unsigned r = $urandom_range(0, 9);
        return (r < 7) ? legal[r] : 6'($urandom);
    endfunction

    initial begin
        rst1 = 1'b0; rst3 = 1'b0; op1 = '0; op3 = '0;
        @(negedge clk);
        hold_reset(1, 3);
        run_instr(1, OP_R, -1);
        run_instr(1, OP_LW, -1);
        run_instr(1, OP_SW, -1);
        run_instr(1, OP_BEQ, -1);
        run_instr(1, OP_BNE, -1);
        run_instr(1, OP_J, -1);
        run_instr(1, OP_ADDI, -1);
        run_instr(1, 6'b111111, -1);
        for (int n = 0; n < 40; n++) run_instr(1, rand_op(), -1);

        hold_reset(3, 2);
        run_instr(3, OP_LW, -1);
        run_instr(3, 6'b111111, -1);
        run_instr(3, OP_SW, 6);
        hold_reset(3, 2);
        run_instr(3, OP_SW, -1);
        for (int n = 0; n < 40; n++) run_instr(3, rand_op(), -1);
        #1;
        check("final_fetch", 32'(st3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
